md_seq: RTL and testbench

MD_SEQ -- requirements
Module: md_seq

---
 rtl/md_seq.sv | 237 +++++++++++++++++++++++
 tb/tb_md_seq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/md_seq.sv
// md_seq: iterative unsigned multiply/divide sequencer with hi/lo result
// registers. All arithmetic wider than the 6-bit iteration counter goes through
// the external shared ALU, one operation per compute cycle. The ALU controls
// are registered, so each state computes the controls for the state it enters.
module md_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  func,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   output logic [1:0]  alu_op,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   input  logic [31:0] alu_out,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL_ADD,
      S_MUL_CMP,
      S_DIV_CMP,
      S_DIV_SUB,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      F_MULTU = 2'b00,
      F_DIVU  = 2'b01,
      F_MTHI  = 2'b10,
      F_MTLO  = 2'b11
   } func_t;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_CMP = 2'b11;

   state_t      state_q, state_d;
   logic [31:0] rs_l_q, rs_l_d;
   logic [31:0] rt_l_q, rt_l_d;
   logic [31:0] acc_hi_q, acc_hi_d;
   logic [31:0] mq_q, mq_d;
   logic [31:0] sum_q, sum_d;
   logic [31:0] r_q, r_d;
   logic        msb_q, msb_d;
   logic        take_q, take_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [1:0]  alu_op_q, alu_op_d;
   logic [31:0] alu_a_q, alu_a_d;
   logic [31:0] alu_b_q, alu_b_d;
   logic        carry;
   logic        last_iter;

   // Next-state, datapath and registered-output computation.
   always_comb begin
      state_d   = state_q;
      rs_l_d    = rs_l_q;
      rt_l_d    = rt_l_q;
      acc_hi_d  = acc_hi_q;
      mq_d      = mq_q;
      sum_d     = sum_q;
      r_d       = r_q;
      msb_d     = msb_q;
      take_d    = take_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      alu_op_d  = ALU_ADD;
      alu_a_d   = '0;
      alu_b_d   = '0;
      carry     = (alu_out == 32'd1);
      last_iter = (cnt_q == 6'd31);

      case (state_q)
         S_IDLE: begin
            busy_d = 1'b0;
            if (start) begin
               case (func_t'(func))
                  F_MULTU: begin
                     rs_l_d   = rs;
                     rt_l_d   = rt;
                     acc_hi_d = '0;
                     mq_d     = rt;
                     cnt_d    = '0;
                     busy_d   = 1'b1;
                     state_d  = S_MUL_ADD;
                     alu_op_d = ALU_ADD;
                     alu_a_d  = '0;
                     alu_b_d  = rt[0] ? rs : '0;
                  end
                  F_DIVU: begin
                     rs_l_d   = rs;
                     rt_l_d   = rt;
                     mq_d     = rs;
                     cnt_d    = '0;
                     busy_d   = 1'b1;
                     // First remainder shift is folded into the start edge so
                     // the compare in DIV_CMP sees the shifted value directly.
                     msb_d    = 1'b0;
                     r_d      = {31'd0, rs[31]};
                     state_d  = S_DIV_CMP;
                     alu_op_d = ALU_CMP;
                     alu_a_d  = rt;
                     alu_b_d  = {31'd0, rs[31]};
                  end
                  F_MTHI: hi_d = rs;
                  default: lo_d = rs;
               endcase
            end
         end

         S_MUL_ADD: begin
            sum_d    = alu_out;
            state_d  = S_MUL_CMP;
            alu_op_d = ALU_CMP;
            alu_a_d  = alu_b_q;
            alu_b_d  = alu_out;
         end

         S_MUL_CMP: begin
            // Sum wrapped iff addend > sum; that carry is the 33rd sum bit.
            acc_hi_d = {carry, sum_q[31:1]};
            mq_d     = {sum_q[0], mq_q[31:1]};
            cnt_d    = cnt_q + 6'd1;
            if (last_iter) begin
               hi_d    = {carry, sum_q[31:1]};
               lo_d    = {sum_q[0], mq_q[31:1]};
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               state_d  = S_MUL_ADD;
               alu_op_d = ALU_ADD;
               alu_a_d  = {carry, sum_q[31:1]};
               alu_b_d  = mq_q[1] ? rs_l_q : '0;
            end
         end

         S_DIV_CMP: begin
            take_d   = msb_q | (alu_out != 32'd1);
            state_d  = S_DIV_SUB;
            alu_op_d = ALU_SUB;
            alu_a_d  = r_q;
            alu_b_d  = (msb_q | (alu_out != 32'd1)) ? rt_l_q : '0;
         end

         S_DIV_SUB: begin
            mq_d  = {mq_q[30:0], take_q};
            cnt_d = cnt_q + 6'd1;
            if (last_iter) begin
               r_d     = alu_out;
               hi_d    = alu_out;
               lo_d    = {mq_q[30:0], take_q};
               done_d  = 1'b1;
               state_d = S_DONE;
            end else begin
               // Next shift pulls in the dividend bit now at mq[30].
               msb_d    = alu_out[31];
               r_d      = {alu_out[30:0], mq_q[30]};
               state_d  = S_DIV_CMP;
               alu_op_d = ALU_CMP;
               alu_a_d  = rt_l_q;
               alu_b_d  = {alu_out[30:0], mq_q[30]};
            end
         end

         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         rs_l_q   <= '0;
         rt_l_q   <= '0;
         acc_hi_q <= '0;
         mq_q     <= '0;
         sum_q    <= '0;
         r_q      <= '0;
         msb_q    <= 1'b0;
         take_q   <= 1'b0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         alu_op_q <= ALU_ADD;
         alu_a_q  <= '0;
         alu_b_q  <= '0;
      end else begin
         state_q  <= state_d;
         rs_l_q   <= rs_l_d;
         rt_l_q   <= rt_l_d;
         acc_hi_q <= acc_hi_d;
         mq_q     <= mq_d;
         sum_q    <= sum_d;
         r_q      <= r_d;
         msb_q    <= msb_d;
         take_q   <= take_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         alu_op_q <= alu_op_d;
         alu_a_q  <= alu_a_d;
         alu_b_q  <= alu_b_d;
      end
   end

   assign alu_op = alu_op_q;
   assign alu_a  = alu_a_q;
   assign alu_b  = alu_b_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign hi     = hi_q;
   assign lo     = lo_q;

endmodule

// File: tb/tb_md_seq.sv
// tb_md_seq: directed bench for md_seq with a behavioural shared ALU.
module tb_md_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  func;
   logic [31:0] rs;
   logic [31:0] rt;
   logic [1:0]  alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_out;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;
   logic [31:0] prev_hi;
   logic [31:0] prev_lo;

   md_seq dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .func   (func),
      .rs     (rs),
      .rt     (rt),
      .alu_op (alu_op),
      .alu_a  (alu_a),
      .alu_b  (alu_b),
      .alu_out(alu_out),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Shared ALU model.
   always_comb begin
      alu_out = '0;
      case (alu_op)
         2'b00: alu_out = alu_a + alu_b;
         2'b01: alu_out = alu_a - alu_b;
         2'b11: alu_out = (alu_a > alu_b) ? 32'd1 : ((alu_a == alu_b) ? 32'd0 : 32'hFFFF_FFFF);
         default: alu_out = '0;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Called right after a negedge; runs one multu/divu to completion.
   task automatic run_op(input string tag, input logic [1:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
      int n;
      start = 1'b1; func = f; rs = a; rt = b;
      @(negedge clk);
      start = 1'b0; rs = $urandom; rt = $urandom;
      chk({tag, " busy_rise"}, {31'd0, busy}, 32'd1);
      chk({tag, " hi_held"}, hi, prev_hi);
      chk({tag, " lo_held"}, lo, prev_lo);
      // mthi request while busy must be ignored
      start = 1'b1; func = 2'b10;
      @(negedge clk);
      start = 1'b0;
      n = 2;
      while (done !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " done_cycle"}, n, 32'd65);
      chk({tag, " hi"}, hi, exp_hi);
      chk({tag, " lo"}, lo, exp_lo);
      chk({tag, " busy_in_done"}, {31'd0, busy}, 32'd1);
      @(negedge clk);
      chk({tag, " done_fall"}, {31'd0, done}, 32'd0);
      chk({tag, " busy_fall"}, {31'd0, busy}, 32'd0);
      chk({tag, " idle_alu_b"}, alu_b, 32'd0);
      prev_hi = exp_hi;
      prev_lo = exp_lo;
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; func = 2'b00; rs = '0; rt = '0;
      #12;
      chk("rst busy", {31'd0, busy}, 32'd0);
      chk("rst done", {31'd0, done}, 32'd0);
      chk("rst hi", hi, 32'd0);
      chk("rst lo", lo, 32'd0);
      chk("rst alu_op", {30'd0, alu_op}, 32'd0);

      // First edge with reset released accepts mthi, then mtlo
      @(negedge clk);
      reset = 1'b1; start = 1'b1; func = 2'b10; rs = 32'h1234_5678;
      @(negedge clk);
      chk("mthi hi", hi, 32'h1234_5678);
      chk("mthi lo", lo, 32'd0);
      chk("mthi busy", {31'd0, busy}, 32'd0);
      chk("mthi done", {31'd0, done}, 32'd0);
      func = 2'b11; rs = 32'hCAFE_F00D;
      @(negedge clk);
      start = 1'b0;
      chk("mtlo lo", lo, 32'hCAFE_F00D);
      chk("mtlo hi", hi, 32'h1234_5678);
      chk("mtlo busy", {31'd0, busy}, 32'd0);
      chk("mtlo done", {31'd0, done}, 32'd0);
      prev_hi = 32'h1234_5678;
      prev_lo = 32'hCAFE_F00D;

      run_op("mul 7x9", 2'b00, 32'd7, 32'd9, 32'd0, 32'h0000_003F);
      run_op("mul max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("mul x10", 2'b00, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780);
      run_op("div 100/7", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14);
      run_op("div big", 2'b01, 32'h8000_0001, 32'hFFFF_FFFF, 32'h8000_0001, 32'd0);
      run_op("div by0", 2'b01, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
      run_op("div x10", 2'b01, 32'hDEAD_BEEF, 32'h10, 32'hF, 32'h0DEA_DBEE);

      // Reset mid-operation, with an ignored multu request in between
      start = 1'b1; func = 2'b01; rs = 32'd100; rt = 32'd7;
      @(negedge clk);
      start = 1'b0;
      for (int c = 1; c < 10; c++) @(negedge clk);
      start = 1'b1; func = 2'b00; rs = 32'd3; rt = 32'd4;
      @(negedge clk);
      start = 1'b0;
      for (int c = 11; c < 20; c++) @(negedge clk);
      chk("restart ignored a", {31'd0, alu_op[0]}, 32'd1);
      @(negedge clk);
      chk("restart ignored b", {31'd0, alu_op[0]}, 32'd1);
      chk("restart busy", {31'd0, busy}, 32'd1);
      for (int c = 21; c < 30; c++) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("midrst busy", {31'd0, busy}, 32'd0);
      chk("midrst done", {31'd0, done}, 32'd0);
      chk("midrst hi", hi, 32'd0);
      chk("midrst lo", lo, 32'd0);
      chk("midrst alu_a", alu_a, 32'd0);
      chk("midrst alu_b", alu_b, 32'd0);
      chk("midrst alu_op", {30'd0, alu_op}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      prev_hi = 32'd0;
      prev_lo = 32'd0;
      run_op("mul 3x4", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
